// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 32-bit ALU. It decodes the instruction, reads operands with a
// writeback bypass, and holds back RAW/WAW hazards using a pending-write scoreboard.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] In1,
  output logic [DATA_W-1:0] In2,
  output logic [3:0]        opcode,
  output logic [2:0]        SR_Cont,
  output logic [4:0]        SR_Bit,
  output logic [3:0]        out_rd,
  output logic              illegal_op
);

  localparam int unsigned AW     = 4;
  localparam int unsigned OPW    = 4;
  localparam logic [OPW-1:0] OP_MAX = OPW'(5);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d, clr_c, set_c;

  logic [OPW-1:0] op_c;
  logic [AW-1:0]  rd_c, rs1_c, rs2_c;
  logic [2:0]     sc_c;
  logic [4:0]     sb_c;
  logic           legal_c, hz_c, slot_free_c, accept_c, issue_c;
  logic [DATA_W-1:0] opa_c, opb_c;
  logic           unused_c;

  logic              out_valid_q, illegal_q;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [OPW-1:0]    opcode_q;
  logic [2:0]        sr_cont_q;
  logic [4:0]        sr_bit_q;
  logic [AW-1:0]     out_rd_q;

  assign op_c     = in_instr[31:28];
  assign rd_c     = in_instr[27:24];
  assign rs1_c    = in_instr[23:20];
  assign rs2_c    = in_instr[19:16];
  assign sc_c     = in_instr[15:13];
  assign sb_c     = in_instr[12:8];
  assign unused_c = ^in_instr[7:0];

  assign legal_c = (op_c <= OP_MAX);

  // Writeback clears pending this cycle, so a hazard it resolves does not stall.
  always_comb begin
    clr_c = '0;
    if (wb_en) clr_c[wb_addr] = 1'b1;
    clr_c[0] = 1'b0;
  end

  assign hz_c = (pend_q[rs1_c] & ~clr_c[rs1_c]) |
                (pend_q[rs2_c] & ~clr_c[rs2_c]) |
                (pend_q[rd_c]  & ~clr_c[rd_c]);

  assign slot_free_c = !out_valid_q || out_ready;
  // Illegal opcodes are dropped, so only the output slot gates them.
  assign in_ready    = legal_c ? (slot_free_c && !hz_c) : slot_free_c;
  assign accept_c    = in_valid && in_ready;
  assign issue_c     = accept_c && legal_c;

  always_comb begin
    set_c = '0;
    if (issue_c && rd_c != '0) set_c[rd_c] = 1'b1;
    pend_d    = (pend_q & ~clr_c) | set_c;
    pend_d[0] = 1'b0;
  end

  // Operand read with same-cycle writeback bypass; r0 reads as zero.
  always_comb begin
    opa_c = rf_q[rs1_c];
    opb_c = rf_q[rs2_c];
    if (wb_en && wb_addr == rs1_c) opa_c = wb_data;
    if (wb_en && wb_addr == rs2_c) opb_c = wb_data;
    if (rs1_c == '0) opa_c = '0;
    if (rs2_c == '0) opb_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (wb_en && wb_addr != '0) rf_q[wb_addr] <= wb_data;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      opcode_q    <= '0;
      sr_cont_q   <= '0;
      sr_bit_q    <= '0;
      out_rd_q    <= '0;
    end else begin
      illegal_q <= accept_c && !legal_c;
      if (issue_c) begin
        out_valid_q <= 1'b1;
        in1_q       <= opa_c;
        in2_q       <= opb_c;
        opcode_q    <= op_c;
        sr_cont_q   <= sc_c;
        sr_bit_q    <= sb_c;
        out_rd_q    <= rd_c;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign illegal_op = illegal_q;
  assign In1        = in1_q;
  assign In2        = in2_q;
  assign opcode     = opcode_q;
  assign SR_Cont    = sr_cont_q;
  assign SR_Bit     = sr_bit_q;
  assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver runs a behavioural model and queues
// expected bundles, and a monitor pops and compares them at every output handshake.
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [2:0]  sc;
    logic [4:0]  sb;
    logic [3:0]  rd;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, wb_en, out_ready;
  logic [31:0] in_instr, wb_data;
  logic [3:0]  wb_addr;
  logic        in_ready, out_valid, illegal_op;
  logic [31:0] In1, In2;
  logic [3:0]  opcode, out_rd;
  logic [2:0]  SR_Cont;
  logic [4:0]  SR_Bit;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] regs [16];
  bit          pend [16];
  bit          m_ov;
  bit          m_ill;
  bundle_t     q[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .In1(In1), .In2(In2),
    .opcode(opcode), .SR_Cont(SR_Cont), .SR_Bit(SR_Bit), .out_rd(out_rd),
    .illegal_op(illegal_op)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                     input int sc, input int sb);
    logic [3:0] o, d, s1, s2;
    logic [2:0] c;
    logic [4:0] b;
    o = 4'(op); d = 4'(rd); s1 = 4'(rs1); s2 = 4'(rs2); c = 3'(sc); b = 5'(sb);
    return {o, d, s1, s2, c, b, 8'h00};
  endfunction

  function automatic bit busy(input logic [3:0] r, input logic we, input logic [3:0] wa);
    return pend[r] && !(we && wa == r);
  endfunction

  function automatic logic [31:0] operand(input logic [3:0] r, input logic we,
                                          input logic [3:0] wa, input logic [31:0] wd);
    if (r == 4'd0) return 32'd0;
    if (we && wa == r) return wd;
    return regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      regs[i] = 32'd0;
      pend[i] = 1'b0;
    end
    m_ov  = 1'b0;
    m_ill = 1'b0;
    q.delete();
  endtask

  // One clock: drive inputs after the edge, check and advance the model mid-cycle.
  task automatic step(input logic v, input logic [31:0] ins, input logic we,
                      input logic [3:0] wa, input logic [31:0] wd, input logic ordy);
    logic [3:0] op, rd, rs1, rs2;
    bit legal, hz, slot, exp_rdy, acc;
    bundle_t e;
    @(posedge clk); #1;
    in_valid = v; in_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    @(negedge clk); #2;
    op = ins[31:28]; rd = ins[27:24]; rs1 = ins[23:20]; rs2 = ins[19:16];
    legal   = (op <= 4'd5);
    hz      = busy(rs1, we, wa) || busy(rs2, we, wa) || busy(rd, we, wa);
    slot    = !m_ov || ordy;
    exp_rdy = legal ? (slot && !hz) : slot;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    acc   = v && exp_rdy;
    m_ill = acc && !legal;
    if (acc && legal) begin
      e.a  = operand(rs1, we, wa, wd);
      e.b  = operand(rs2, we, wa, wd);
      e.op = op; e.sc = ins[15:13]; e.sb = ins[12:8]; e.rd = rd;
      q.push_back(e);
    end
    m_ov = (acc && legal) ? 1'b1 : (m_ov && !ordy);
    if (we) pend[wa] = 1'b0;
    if (acc && legal && rd != 4'd0) pend[rd] = 1'b1;
    if (we && wa != 4'd0) regs[wa] = wd;
  endtask

  // Monitor: pops the expected bundle at each handshake.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() != 0) begin
          e = q.pop_front();
          chk("In1", In1, e.a);
          chk("In2", In2, e.b);
          chk("opcode", 32'(opcode), 32'(e.op));
          chk("SR_Cont", 32'(SR_Cont), 32'(e.sc));
          chk("SR_Bit", 32'(SR_Bit), 32'(e.sb));
          chk("out_rd", 32'(out_rd), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    int op;
    in_valid = 0; in_instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_In1", In1, 32'd0);
    chk("rst_In2", In2, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_SR", {24'd0, SR_Cont, SR_Bit}, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);

    // Basic issue after writebacks
    step(0, 0, 1, 4'd3, 32'h0000_0010, 1);
    step(0, 0, 1, 4'd4, 32'h0000_0003, 1);
    step(1, mk(0, 5, 3, 4, 3'b010, 2), 0, 0, 0, 1);
    // RAW on r5: stall, then bypass resolves it
    step(1, mk(1, 6, 5, 4, 0, 0), 0, 0, 0, 1);
    step(1, mk(1, 6, 5, 4, 0, 0), 0, 0, 0, 1);
    step(1, mk(1, 6, 5, 4, 0, 0), 1, 4'd5, 32'hDEAD_BEEF, 1);
    // Illegal opcode leaves no pending bit for r8
    step(1, mk(9, 8, 1, 2, 0, 0), 0, 0, 0, 1);
    step(1, mk(2, 10, 8, 0, 0, 0), 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // r0 is hardwired to zero and never becomes pending
    step(0, 0, 1, 4'd0, 32'hFFFF_FFFF, 1);
    step(1, mk(3, 0, 0, 0, 1, 7), 0, 0, 0, 1);
    step(1, mk(4, 0, 0, 3, 4, 31), 0, 0, 0, 1);
    // Backpressure: bundle held for four cycles, then back-to-back load
    step(1, mk(5, 9, 3, 4, 5, 9), 0, 0, 0, 0);
    repeat (4) step(1, mk(0, 11, 3, 4, 0, 1), 0, 0, 0, 0);
    step(1, mk(0, 11, 3, 4, 0, 1), 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Async reset while a bundle is held and r7 is pending
    step(1, mk(1, 7, 3, 4, 0, 0), 1, 4'd6, 32'h1234_5678, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    in_valid = 0; wb_en = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_In1", In1, 32'd0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    step(1, mk(0, 12, 7, 3, 0, 0), 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      op  = ($urandom_range(0, 99) < 12) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
      ins = mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
      step(1'($urandom_range(0, 99) < 80), ins, 1'($urandom_range(0, 99) < 35),
           4'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 99) < 70));
    end

    repeat (4) step(0, 0, 0, 0, 0, 1);
    chk("drain_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
